// File: rtl/mld_7_4_pkg.sv
// Shared constants, check-sum masks and FSM state type for the (7,4) cyclic
// Hamming majority-logic decoder. Vectors use bit order [0:6], where bit i is
// the coefficient of x^i.
package mld_7_4_pkg;

    localparam int N = 7;

    // Check sums orthogonal on b6: each mask includes b6. Every other
    // position appears in exactly two of the four masks.
    localparam logic [0:N-1] CHK1 = 7'b0010111;  // b2 b4 b5 b6
    localparam logic [0:N-1] CHK2 = 7'b1001011;  // b0 b3 b5 b6
    localparam logic [0:N-1] CHK3 = 7'b1100101;  // b0 b1 b4 b6
    localparam logic [0:N-1] CHK4 = 7'b0111001;  // b1 b2 b3 b6

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic check_sum(input logic [0:N-1] word,
                                       input logic [0:N-1] mask);
        return ^(word & mask);
    endfunction

endpackage

// File: rtl/mld_7_4_majority_gate.sv
// Majority gate: four parity checks on the current buffer followed by a
// 3-of-4 vote. The vote is high only when b6 is the erroneous position. A
// single error elsewhere disturbs only two of the four sums.
module mld_7_4_majority_gate
    import mld_7_4_pkg::*;
(
    input  logic [0:N-1] buffer,
    output logic         error_value
);

    logic a1, a2, a3, a4;

    // Parity checks and majority vote.
    always_comb begin
        a1 = check_sum(buffer, CHK1);
        a2 = check_sum(buffer, CHK2);
        a3 = check_sum(buffer, CHK3);
        a4 = check_sum(buffer, CHK4);
        error_value = (a1 & a2 & a3) | (a1 & a2 & a4) |
                      (a1 & a3 & a4) | (a2 & a3 & a4);
    end

endmodule

// File: rtl/mld_7_4_decoder.sv
// Serial-in majority-logic decoder for the cyclic (7,4) Hamming code with
// g(x) = 1 + x + x^3. The decoder shifts in seven received bits, then
// rotates the word seven times. On each rotation it corrects the bit that
// is leaving b6.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | after reset; buffer holds zeros
//  LOAD   | shifting received bits in while load=1
//  DECODE | one cyclic shift per clock, b6 corrected on its way to b0
//  DONE   | corrected word held on decoded_vector
module mld_7_4_decoder
    import mld_7_4_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         received_bit_stream,
    output logic [0:6]   decoded_vector
);

    state_t       state, state_next;
    logic [0:N-1] buffer, buffer_next;
    logic [2:0]   counter, counter_next;
    logic         error_value;

    mld_7_4_majority_gate u_majority (
        .buffer      (buffer),
        .error_value (error_value)
    );

    assign decoded_vector = buffer;

    // Register update. Reset takes priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            buffer  <= '0;
            counter <= '0;
        end else begin
            state   <= state_next;
            buffer  <= buffer_next;
            counter <= counter_next;
        end
    end

    // Next state, buffer and counter. A load in any state restarts the
    // word. This includes a load that arrives mid-decode.
    always_comb begin
        state_next   = state;
        buffer_next  = buffer;
        counter_next = counter;
        if (load) begin
            state_next   = LOAD;
            buffer_next  = {buffer[1:N-1], received_bit_stream};
            counter_next = '0;
        end else begin
            case (state)
                LOAD: begin
                    state_next   = DECODE;
                    counter_next = '0;
                end
                DECODE: begin
                    // Multiply by x modulo x^7-1. The bit wrapping into b0 is corrected.
                    buffer_next  = {buffer[N-1] ^ error_value, buffer[0:N-2]};
                    counter_next = counter + 3'd1;
                    if (counter == 3'(N - 1))
                        state_next = DONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mld_7_4_decoder.sv
// Directed scoreboard bench for mld_7_4_decoder. Expected correction cycles
// and final words come from a brute-force nearest-codeword search over all
// 16 codewords of g(x) = 1 + x + x^3.
module tb_mld_7_4_decoder;
    import mld_7_4_pkg::*;

    logic       clk;
    logic       reset;
    logic       load;
    logic       received_bit_stream;
    logic [0:6] decoded_vector;

    int total = 0;
    int bad   = 0;

    logic err_q[$];
    logic [0:6] word_q[$];

    mld_7_4_decoder dut (
        .clk                 (clk),
        .reset               (reset),
        .load                (load),
        .received_bit_stream (received_bit_stream),
        .decoded_vector      (decoded_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [0:6] encode(input logic [3:0] m);
        logic [0:6] c;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            if (m[j]) begin
                c[j]   = ~c[j];
                c[j+1] = ~c[j+1];
                c[j+3] = ~c[j+3];
            end
        end
        return c;
    endfunction

    function automatic logic [0:6] nearest(input logic [0:6] r);
        logic [0:6] c;
        for (int m = 0; m < 16; m++) begin
            c = encode(4'(m));
            if ($countones(c ^ r) <= 1) return c;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // The bit at original position p reaches b6 on decode cycle 6-p.
    task automatic push_expected(input logic [0:6] w);
        logic [0:6] cw;
        logic [0:6] d;
        cw = nearest(w);
        d  = cw ^ w;
        for (int k = 0; k < 7; k++) err_q.push_back(d[6-k]);
        word_q.push_back(cw);
    endtask

    task automatic shift_bits(input logic [0:15] bits, input int len);
        for (int i = 0; i < len; i++) begin
            load = 1'b1;
            received_bit_stream = bits[i];
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        received_bit_stream = 1'b0;
    endtask

    task automatic load_word(input string tag, input logic [0:6] w);
        logic [0:15] bits;
        bits = '0;
        for (int i = 0; i < 7; i++) bits[i] = w[i];
        shift_bits(bits, 7);
        push_expected(w);
        @(negedge clk);
        check({tag, "_loaded"}, decoded_vector, w);
    endtask

    task automatic wait_decode(input string tag);
        int waited;
        waited = 0;
        while (dut.state != DECODE && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_enter_decode"}, 7'(dut.state), 7'(DECODE));
    endtask

    task automatic run_decode(input string tag);
        logic       e;
        logic [0:6] w;
        wait_decode(tag);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge clk);
            if (err_q.size() == 0) begin
                check({tag, "_err_queue_empty"}, 7'd1, 7'd0);
            end else begin
                e = err_q.pop_front();
                check($sformatf("%s_error_value_k%0d", tag, k), 7'(dut.error_value), 7'(e));
            end
        end
        @(negedge clk);
        check({tag, "_state_done"}, 7'(dut.state), 7'(DONE));
        if (word_q.size() == 0) begin
            check({tag, "_word_queue_empty"}, 7'd1, 7'd0);
        end else begin
            w = word_q.pop_front();
            check({tag, "_result"}, decoded_vector, w);
            repeat (3) @(negedge clk);
            check({tag, "_held"}, decoded_vector, w);
        end
    endtask

    initial begin
        logic [0:15] bits;
        reset = 1'b1;
        load = 1'b0;
        received_bit_stream = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_vector", decoded_vector, 7'b0000000);
        check("reset_state", 7'(dut.state), 7'(IDLE));
        check("reset_counter", 7'(dut.counter), 7'd0);

        // Single error at bit 5.
        load_word("t1", 7'b1100111);
        run_decode("t1");

        // Valid codeword.
        load_word("t2", 7'b1100101);
        run_decode("t2");

        // Error in b6.
        load_word("t3", 7'b1100100);
        run_decode("t3");

        // All zeros.
        load_word("t4", 7'b0000000);
        run_decode("t4");

        // Reset during the third decode cycle.
        load_word("t5", 7'b1100111);
        wait_decode("t5");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        err_q.delete();
        word_q.delete();
        @(negedge clk);
        check("t5_reset_vector", decoded_vector, 7'b0000000);
        check("t5_reset_state", 7'(dut.state), 7'(IDLE));
        repeat (2) @(negedge clk);
        check("t5_no_rotation", decoded_vector, 7'b0000000);
        check("t5_still_idle", 7'(dut.state), 7'(IDLE));

        // Load reasserted mid-decode.
        load_word("t6a", 7'b0110011);
        wait_decode("t6a");
        repeat (3) @(negedge clk);
        err_q.delete();
        word_q.delete();
        load_word("t6b", 7'b1011000);
        check("t6b_state_load", 7'(dut.state), 7'(LOAD));
        run_decode("t6b");

        // A nine-bit load keeps the last seven bits. An error at b0 is corrected on the final cycle.
        bits = '0;
        bits[0:8] = 9'b110100101;
        shift_bits(bits, 9);
        push_expected(7'b0100101);
        @(negedge clk);
        check("t7_loaded", decoded_vector, 7'b0100101);
        run_decode("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
